// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx line, 16x oversampled centre sampling, 5..DATA_WIDTH
// data bits LSB-first, 1 or 2 stop bits, valid/ready output with framing/overrun pulses.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                          clk_i,
  input  logic                          s_rst_i,
  input  logic                          enable_i,
  input  logic                          baud_tick_i,
  input  logic                          rx_i,
  input  logic                          stop_bit_num_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] data_bit_num_i,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_err_o,
  output logic                          overrun_o
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       nbits_q, nbits_d;
  logic                  stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  deliver;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nbits_d = nbits_q;
    stop2_d = stop2_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~ready_i;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;

    if (baud_tick_i) begin
      case (state_q)
        StIdle: begin
          if (enable_i && !rx_s_q) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              nbits_d = data_bit_num_i;
              stop2_d = stop_bit_num_i;
              shift_d = '0;
              idx_d   = '0;
              cnt_d   = '0;
              state_d = StData;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == CntLast) begin
            cnt_d          = '0;
            // Writing at the bit index leaves the word right-justified.
            shift_d[idx_q] = rx_s_q;
            if (idx_q == nbits_q) begin
              state_d = StStop;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (!rx_s_q) begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end else if (stop2_q) begin
              stop2_d = 1'b0;
            end else begin
              deliver = 1'b1;
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StBreak: begin
          if (rx_s_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (deliver) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~ready_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      nbits_q   <= '0;
      stop2_q   <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      nbits_q   <= nbits_d;
      stop2_q   <= stop2_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule
